// File: rtl/digimax_pkg.sv
// Shared constants for the digimax read-side sampler: register map, bit positions
// and the silence code returned when no sample is available.
package digimax_pkg;

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_STATUS = 3'd1,
        REG_CTRL   = 3'd2,
        REG_LAST   = 3'd3
    } reg_addr_e;

    localparam int unsigned ST_EMPTY    = 7;
    localparam int unsigned ST_FULL     = 6;
    localparam int unsigned ST_OVERFLOW = 5;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned CMD_CLR_OVF = 0;
    localparam int unsigned CMD_FLUSH   = 1;

    localparam logic [7:0] SILENCE  = 8'h80;
    localparam logic [7:0] UNMAPPED = 8'hFF;

    // Status only has five bits for the count; larger FIFOs pin at 31.
    function automatic logic [4:0] sat_count(input int unsigned c);
        return (c > 31) ? 5'd31 : 5'(c);
    endfunction

endpackage

// File: rtl/digimax_sampler_if.sv
// Host-side bus of the sampler: PCM input stream plus the CPU register window.
interface digimax_sampler_if #(
    parameter int unsigned IN_WIDTH = 16
);
    logic signed [IN_WIDTH-1:0] audio_in;
    logic                       audio_strobe;
    logic                       rd_n;
    logic                       wr_n;
    logic [2:0]                 addr;
    logic [7:0]                 data_in;
    logic [7:0]                 data_out;
    logic                       irq;

    modport master (
        output audio_in, audio_strobe, rd_n, wr_n, addr, data_in,
        input  data_out, irq
    );

    modport slave (
        input  audio_in, audio_strobe, rd_n, wr_n, addr, data_in,
        output data_out, irq
    );
endinterface

// File: rtl/sampler_fifo.sv
// First-word-fall-through sample FIFO; a push into a full FIFO is accepted only when a
// pop retires the head in the same cycle, otherwise it is dropped and flagged.
module sampler_fifo #(
    parameter int unsigned FIFO_LOG2 = 4,
    parameter int unsigned WIDTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [FIFO_LOG2:0] count,
    output logic             full,
    output logic             empty,
    output logic             dropped
);
    localparam int unsigned DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = (FIFO_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop & ~flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/digimax_sampler.sv
// 8-bit audio sampler: box-car decimates signed PCM, converts to offset binary and
// buffers it for a CPU that polls status and pops bytes through a small register window.
module digimax_sampler
    import digimax_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned FIFO_LOG2  = 4
) (
    input logic               clk,
    input logic               reset,
    digimax_sampler_if.slave  bus
);
    localparam int unsigned AW = IN_WIDTH + DECIM_LOG2;
    localparam int unsigned PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);
    localparam logic [FIFO_LOG2:0] HALF_CNT = (FIFO_LOG2 + 1)'(1 << (FIFO_LOG2 - 1));

    logic                 rd_n_q;
    logic                 wr_n_q;
    logic [7:0]           data_out_q;
    logic                 irq_q;
    logic                 overflow_q;
    logic                 enable_q;
    logic                 irq_en_q;
    logic signed [AW-1:0] acc_q;
    logic [PW-1:0]        phase_q;
    logic [7:0]           last_q;

    logic                 rd_fall;
    logic                 wr_fall;
    logic signed [AW-1:0] audio_ext;
    logic signed [AW-1:0] acc_next;
    logic                 take_sample;
    logic                 wrap;
    logic [7:0]           sample_out;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 clr_ovf;
    logic [7:0]           fifo_dout;
    logic [FIFO_LOG2:0]   fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_dropped;
    logic [7:0]           status;
    logic [7:0]           rd_data;
    logic                 unused_data_in;

    // Accesses act only on the first low cycle of each strobe.
    assign rd_fall = rd_n_q & ~bus.rd_n;
    assign wr_fall = wr_n_q & ~bus.wr_n;

    assign audio_ext   = AW'(signed'(bus.audio_in));
    assign acc_next    = acc_q + audio_ext;
    assign take_sample = enable_q & bus.audio_strobe;
    assign wrap        = take_sample & (phase_q == PHASE_LAST);
    assign sample_out  = {~acc_next[AW-1], acc_next[AW-2 -: 7]};

    assign fifo_pop   = rd_fall & (bus.addr == REG_DATA);
    assign fifo_flush = wr_fall & (bus.addr == REG_STATUS) & bus.data_in[CMD_FLUSH];
    assign clr_ovf    = wr_fall & (bus.addr == REG_STATUS) & bus.data_in[CMD_CLR_OVF];

    assign unused_data_in = ^bus.data_in[7:3];

    sampler_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wrap),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .din     (sample_out),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .dropped (fifo_dropped)
    );

    always_comb begin
        status              = '0;
        status[ST_EMPTY]    = fifo_empty;
        status[ST_FULL]     = fifo_full;
        status[ST_OVERFLOW] = overflow_q;
        status[4:0]         = sat_count(32'(fifo_count));
    end

    always_comb begin
        rd_data = UNMAPPED;
        case (bus.addr)
            REG_DATA:   rd_data = fifo_empty ? SILENCE : fifo_dout;
            REG_STATUS: rd_data = status;
            REG_CTRL: begin
                rd_data              = '0;
                rd_data[CTRL_IRQ_EN] = irq_en_q;
                rd_data[CTRL_ENABLE] = enable_q;
            end
            REG_LAST:   rd_data = last_q;
            default:    rd_data = UNMAPPED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            data_out_q <= SILENCE;
            irq_q      <= 1'b0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            acc_q      <= '0;
            phase_q    <= '0;
            last_q     <= SILENCE;
        end else begin
            rd_n_q <= bus.rd_n;
            wr_n_q <= bus.wr_n;
            irq_q  <= irq_en_q & (fifo_count >= HALF_CNT);

            if (rd_fall) begin
                data_out_q <= rd_data;
            end

            if (wr_fall && bus.addr == REG_CTRL) begin
                enable_q <= bus.data_in[CTRL_ENABLE];
                irq_en_q <= bus.data_in[CTRL_IRQ_EN];
            end

            // A drop in the same cycle as a clear leaves overflow set.
            overflow_q <= (overflow_q & ~clr_ovf) | fifo_dropped;

            if (!enable_q) begin
                acc_q   <= '0;
                phase_q <= '0;
            end else if (wrap) begin
                acc_q   <= '0;
                phase_q <= '0;
                last_q  <= sample_out;
            end else if (take_sample) begin
                acc_q   <= acc_next;
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_digimax_sampler.sv
// Directed bench for digimax_sampler: stimulus queues expected read data, a monitor
// compares data_out after every rd_n falling edge.
module tb_digimax_sampler;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    digimax_sampler_if #(.IN_WIDTH(16)) bus ();

    digimax_sampler #(
        .IN_WIDTH   (16),
        .DECIM_LOG2 (2),
        .FIFO_LOG2  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: data_out is loaded on the edge that sees rd_n first low.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            if (!bus.rd_n && prev && !reset) begin
                prev = bus.rd_n;
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    check("unexpected_read", bus.data_out, 8'hxx);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, bus.data_out, e.value);
                end
            end else begin
                prev = bus.rd_n;
            end
        end
    end

    task automatic cpu_read(input logic [2:0] a, input logic [7:0] exp, input string nm);
        sb_q.push_back('{nm, exp});
        @(negedge clk);
        bus.addr = a;
        bus.rd_n = 1'b0;
        @(negedge clk);
        bus.rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.data_in = d;
        bus.wr_n    = 1'b0;
        @(negedge clk);
        bus.wr_n    = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        bus.audio_in     = v;
        bus.audio_strobe = 1'b1;
        @(negedge clk);
        bus.audio_strobe = 1'b0;
    endtask

    // Four equal samples {b,8'h00} average to byte b; output is b with MSB flipped.
    task automatic window(input logic [15:0] v);
        repeat (4) strobe(v);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] b;
        bus.audio_in     = '0;
        bus.audio_strobe = 1'b0;
        bus.rd_n         = 1'b1;
        bus.wr_n         = 1'b1;
        bus.addr         = '0;
        bus.data_in      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data_out", bus.data_out, 8'h80);
        check("reset_irq", {7'b0, bus.irq}, 8'h00);

        cpu_read(3'd1, 8'h80, "status_after_reset");
        cpu_read(3'd0, 8'h80, "pop_empty");
        cpu_read(3'd2, 8'h00, "ctrl_after_reset");
        cpu_read(3'd3, 8'h80, "last_after_reset");
        cpu_read(3'd5, 8'hFF, "unmapped_addr5");

        // Basic decimation
        cpu_write(3'd2, 8'h01);
        cpu_read(3'd2, 8'h01, "ctrl_enabled");
        window(16'h4000);
        cpu_read(3'd3, 8'hC0, "last_4000");
        cpu_read(3'd1, 8'h01, "status_one");
        cpu_read(3'd0, 8'hC0, "pop_4000");
        cpu_read(3'd1, 8'h80, "status_empty_again");
        window(16'h8000);
        cpu_read(3'd0, 8'h00, "pop_8000");

        // Fill past full: 17 outputs, last one dropped
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 8 + 3);
            window({b, 8'h00});
        end
        cpu_read(3'd1, 8'h70, "status_full_ovf");
        cpu_read(3'd3, 8'h03, "last_after_drop");
        cpu_read(3'd0, 8'h83, "pop_order0");
        cpu_read(3'd0, 8'h8B, "pop_order1");
        cpu_read(3'd1, 8'h2E, "status_14_ovf");
        cpu_write(3'd1, 8'h01);
        cpu_read(3'd1, 8'h0E, "status_ovf_cleared");
        cpu_write(3'd1, 8'h02);
        cpu_read(3'd1, 8'h80, "status_flushed");

        // irq threshold
        cpu_write(3'd2, 8'h05);
        cpu_read(3'd2, 8'h05, "ctrl_irq_en");
        repeat (7) window(16'h1000);
        repeat (2) @(negedge clk);
        check("irq_at_7", {7'b0, bus.irq}, 8'h00);
        repeat (3) strobe(16'h1000);
        @(negedge clk);
        bus.audio_in     = 16'h1000;
        bus.audio_strobe = 1'b1;
        @(negedge clk);
        bus.audio_strobe = 1'b0;
        check("irq_push_cycle", {7'b0, bus.irq}, 8'h00);
        @(negedge clk);
        check("irq_at_8", {7'b0, bus.irq}, 8'h01);
        cpu_read(3'd0, 8'h90, "pop_irq");
        check("irq_after_pop", {7'b0, bus.irq}, 8'h00);
        cpu_read(3'd1, 8'h07, "status_7");

        // Held read strobe pops once
        cpu_write(3'd1, 8'h02);
        window(16'h3100);
        window(16'h3200);
        window(16'h3300);
        sb_q.push_back('{"held_read_pop", 8'hB1});
        @(negedge clk);
        bus.addr = 3'd0;
        bus.rd_n = 1'b0;
        repeat (5) @(negedge clk);
        bus.rd_n = 1'b1;
        @(negedge clk);
        cpu_read(3'd1, 8'h02, "status_after_held_read");

        // Pop and push together while full
        cpu_write(3'd1, 8'h02);
        for (int i = 0; i < 16; i++) begin
            b = 8'(8'h40 + i);
            window({b, 8'h00});
        end
        cpu_read(3'd1, 8'h50, "status_full_before");
        repeat (3) strobe(16'h7F00);
        sb_q.push_back('{"pop_with_push_full", 8'hC0});
        @(negedge clk);
        bus.audio_in     = 16'h7F00;
        bus.audio_strobe = 1'b1;
        bus.addr         = 3'd0;
        bus.rd_n         = 1'b0;
        @(negedge clk);
        bus.audio_strobe = 1'b0;
        repeat (3) @(negedge clk);
        bus.rd_n = 1'b1;
        @(negedge clk);
        cpu_read(3'd1, 8'h50, "status_full_no_ovf");
        cpu_read(3'd3, 8'hFF, "last_7f00");
        cpu_read(3'd0, 8'hC1, "pop_after_wrap");

        // Disable mid-window discards partial sum
        cpu_write(3'd1, 8'h02);
        cpu_write(3'd2, 8'h01);
        strobe(16'h4000);
        strobe(16'h4000);
        cpu_write(3'd2, 8'h00);
        cpu_write(3'd2, 8'h01);
        window(16'h2000);
        cpu_read(3'd0, 8'hA0, "pop_after_discard");
        cpu_read(3'd1, 8'h80, "status_after_discard");
        cpu_read(3'd3, 8'hA0, "last_after_discard");

        // Reset mid-operation
        window(16'h4000);
        strobe(16'h4000);
        strobe(16'h4000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_data_out", bus.data_out, 8'h80);
        cpu_read(3'd1, 8'h80, "midreset_status");
        cpu_read(3'd2, 8'h00, "midreset_ctrl");
        cpu_read(3'd3, 8'h80, "midreset_last");

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
